// File: rtl/traffic_pkg.sv
// Shared types for the traffic-light controller: phase encoding, per-approach
// lamp bundle and the round-robin wrap helper.
package traffic_pkg;

   typedef enum logic [2:0] {
      ALLRED = 3'd0,
      GREEN  = 3'd1,
      YELLOW = 3'd2,
      FLASH  = 3'd3,
      FAIL   = 3'd4
   } phase_t;

   typedef struct packed {
      logic r;
      logic y;
      logic g;
   } lamp_t;

   // Approach index offset from a base, wrapping modulo the approach count.
   function automatic int wrap_add(input int a, input int b, input int n);
      return (a + b) % n;
   endfunction

endpackage

// File: rtl/lamp_checker.sv
// Compares lamp feedback with the commanded lamps; flags conflicting greens or
// green+red at once immediately, and any other disagreement once it persists.
module lamp_checker #(
   parameter int N_DIR        = 2,
   parameter int MISMATCH_CYC = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ignore,
   input  logic [N_DIR-1:0] cmd_r,
   input  logic [N_DIR-1:0] cmd_y,
   input  logic [N_DIR-1:0] cmd_g,
   input  logic [N_DIR-1:0] fb_r,
   input  logic [N_DIR-1:0] fb_y,
   input  logic [N_DIR-1:0] fb_g,
   output logic             fault_set
);

   localparam int            MW   = $clog2(MISMATCH_CYC + 1);
   localparam logic [MW-1:0] LAST = MW'(MISMATCH_CYC - 1);

   logic [MW-1:0] cnt;
   logic          immediate;
   logic          mismatch;
   logic          persist;

   // x & (x-1) is non-zero exactly when two or more greens are lit.
   assign immediate = ((fb_g & (fb_g - N_DIR'(1))) != '0) || ((fb_g & fb_r) != '0);
   assign mismatch  = !ignore && ({fb_r, fb_y, fb_g} != {cmd_r, cmd_y, cmd_g});
   assign persist   = mismatch && (cnt == LAST);
   assign fault_set = immediate || persist;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (!mismatch) begin
         cnt <= '0;
      end else if (cnt != LAST) begin
         cnt <= cnt + MW'(1);
      end
   end

endmodule

// File: rtl/traffic_light_ctrl.sv
// Multi-approach traffic-light controller: round-robin demand-driven greens,
// night flash, and a sticky lamp-fault flag that forces a steady all-red.
module traffic_light_ctrl #(
   parameter int N_DIR        = 2,
   parameter int GREEN_CYC    = 8,
   parameter int YELLOW_CYC   = 3,
   parameter int ALLRED_CYC   = 2,
   parameter int FLASH_CYC    = 4,
   parameter int MISMATCH_CYC = 3,
   parameter int CNT_W        = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     en,
   input  logic                     night,
   input  logic [N_DIR-1:0]         req,
   input  logic                     clr_fault,
   input  logic [N_DIR-1:0]         fb_r,
   input  logic [N_DIR-1:0]         fb_y,
   input  logic [N_DIR-1:0]         fb_g,
   output logic [N_DIR-1:0]         lamp_r,
   output logic [N_DIR-1:0]         lamp_y,
   output logic [N_DIR-1:0]         lamp_g,
   output logic [$clog2(N_DIR)-1:0] cur_dir,
   output logic [2:0]               phase,
   output logic                     fault
);

   import traffic_pkg::*;

   localparam int               DW       = $clog2(N_DIR);
   localparam logic [N_DIR-1:0] ALL      = '1;
   localparam logic [N_DIR-1:0] ONE      = N_DIR'(1);
   localparam logic [CNT_W-1:0] T_GREEN  = CNT_W'(GREEN_CYC - 1);
   localparam logic [CNT_W-1:0] T_YELLOW = CNT_W'(YELLOW_CYC - 1);
   localparam logic [CNT_W-1:0] T_ALLRED = CNT_W'(ALLRED_CYC - 1);
   localparam logic [CNT_W-1:0] T_FLASH  = CNT_W'(FLASH_CYC - 1);

   typedef lamp_t [N_DIR-1:0] lamp_vec_t;

   phase_t           state;
   logic [CNT_W-1:0] timer;
   lamp_vec_t        lamps;
   logic             flash_on;
   logic             fault_set;
   logic [DW-1:0]    nxt_dir;
   logic [N_DIR-1:0] cur_oh;
   logic [N_DIR-1:0] nxt_oh;

   function automatic lamp_vec_t mk(input logic [N_DIR-1:0] r, input logic [N_DIR-1:0] y,
                                    input logic [N_DIR-1:0] g);
      lamp_vec_t v;
      for (int i = 0; i < N_DIR; i++) begin
         v[i] = '{r: r[i], y: y[i], g: g[i]};
      end
      return v;
   endfunction

   // Descending scan so the nearest requester after cur_dir wins; offset
   // N_DIR lands back on cur_dir, which lets a sole requester be re-served.
   always_comb begin
      nxt_dir = DW'(wrap_add(int'(cur_dir), 1, N_DIR));
      for (int i = N_DIR; i >= 1; i--) begin
         if (req[DW'(wrap_add(int'(cur_dir), i, N_DIR))]) begin
            nxt_dir = DW'(wrap_add(int'(cur_dir), i, N_DIR));
         end
      end
   end

   assign cur_oh = ONE << cur_dir;
   assign nxt_oh = ONE << nxt_dir;

   always_comb begin
      lamp_r = '0;
      lamp_y = '0;
      lamp_g = '0;
      for (int i = 0; i < N_DIR; i++) begin
         lamp_r[i] = lamps[i].r;
         lamp_y[i] = lamps[i].y;
         lamp_g[i] = lamps[i].g;
      end
   end

   assign phase = state;

   lamp_checker #(
      .N_DIR        (N_DIR),
      .MISMATCH_CYC (MISMATCH_CYC)
   ) u_checker (
      .clk       (clk),
      .rst_n     (rst_n),
      .ignore    (state == FAIL),
      .cmd_r     (lamp_r),
      .cmd_y     (lamp_y),
      .cmd_g     (lamp_g),
      .fb_r      (fb_r),
      .fb_y      (fb_y),
      .fb_g      (fb_g),
      .fault_set (fault_set)
   );

   // A fresh detection outranks a clear pulse arriving in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fault <= 1'b0;
      end else if (fault_set) begin
         fault <= 1'b1;
      end else if (clr_fault) begin
         fault <= 1'b0;
      end
   end

   // Fault handling bypasses en so a frozen controller still goes safe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ALLRED;
         timer    <= T_ALLRED;
         lamps    <= mk(ALL, '0, '0);
         cur_dir  <= DW'(N_DIR - 1);
         flash_on <= 1'b0;
      end else if (fault && state != FAIL) begin
         state <= FAIL;
         timer <= T_ALLRED;
         lamps <= mk(ALL, '0, '0);
      end else if (state == FAIL) begin
         if (clr_fault && !fault_set) begin
            state <= ALLRED;
            timer <= T_ALLRED;
            lamps <= mk(ALL, '0, '0);
         end
      end else if (en) begin
         if (timer != '0) begin
            timer <= timer - CNT_W'(1);
         end else begin
            case (state)
               ALLRED: begin
                  if (night) begin
                     state    <= FLASH;
                     timer    <= T_FLASH;
                     flash_on <= 1'b1;
                     lamps    <= mk('0, ALL, '0);
                  end else begin
                     state   <= GREEN;
                     timer   <= T_GREEN;
                     cur_dir <= nxt_dir;
                     lamps   <= mk(~nxt_oh, '0, nxt_oh);
                  end
               end
               GREEN: begin
                  state <= YELLOW;
                  timer <= T_YELLOW;
                  lamps <= mk(~cur_oh, cur_oh, '0);
               end
               YELLOW: begin
                  state <= ALLRED;
                  timer <= T_ALLRED;
                  lamps <= mk(ALL, '0, '0);
               end
               FLASH: begin
                  timer <= T_FLASH;
                  if (flash_on) begin
                     flash_on <= 1'b0;
                     lamps    <= mk('0, '0, '0);
                  end else if (!night) begin
                     state <= ALLRED;
                     timer <= T_ALLRED;
                     lamps <= mk(ALL, '0, '0);
                  end else begin
                     flash_on <= 1'b1;
                     lamps    <= mk('0, ALL, '0);
                  end
               end
               default: begin
                  state <= ALLRED;
                  timer <= T_ALLRED;
                  lamps <= mk(ALL, '0, '0);
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl at default parameters; feedback mirrors
// the lamp commands except where a fault is injected.
module tb_traffic_light_ctrl;

   localparam logic [2:0] AR = 3'd0, GR = 3'd1, YE = 3'd2, FL = 3'd3, FA = 3'd4;

   logic       clk = 1'b0, rst_n = 1'b0, en = 1'b1, night = 1'b0, clr_fault = 1'b0;
   logic [1:0] req = 2'b00, inj_r = 2'b00, inj_y = 2'b00, inj_g = 2'b00;
   logic [1:0] fb_r, fb_y, fb_g, lamp_r, lamp_y, lamp_g;
   logic       cur_dir;
   logic [2:0] phase;
   logic       fault;
   int         checks = 0, failures = 0;

   typedef logic [10:0] snap_t;

   typedef struct {
      bit         rst;
      logic [1:0] req;
      logic       night;
      int         n;
      logic [2:0] ph;
      logic       dir;
      logic [1:0] r, y, g;
   } vec_t;

   vec_t tbl[$];

   assign fb_r = lamp_r ^ inj_r;
   assign fb_y = lamp_y ^ inj_y;
   assign fb_g = lamp_g ^ inj_g;

   always #5 clk = ~clk;

   traffic_light_ctrl dut (
      .clk(clk), .rst_n(rst_n), .en(en), .night(night), .req(req), .clr_fault(clr_fault),
      .fb_r(fb_r), .fb_y(fb_y), .fb_g(fb_g),
      .lamp_r(lamp_r), .lamp_y(lamp_y), .lamp_g(lamp_g),
      .cur_dir(cur_dir), .phase(phase), .fault(fault)
   );

   function automatic snap_t snap();
      return {phase, cur_dir, lamp_r, lamp_y, lamp_g, fault};
   endfunction

   function automatic snap_t mk(input logic [2:0] ph, input logic dir, input logic [1:0] r,
                                input logic [1:0] y, input logic [1:0] g, input logic f);
      return {ph, dir, r, y, g, f};
   endfunction

   task automatic chk(input string name, input snap_t exp);
      snap_t got;
      got = snap();
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got ph=%0d dir=%0d r=%b y=%b g=%b fault=%b want ph=%0d dir=%0d r=%b y=%b g=%b fault=%b",
                  name, got[10:8], got[7], got[6:5], got[4:3], got[2:1], got[0],
                  exp[10:8], exp[7], exp[6:5], exp[4:3], exp[2:1], exp[0]);
      end
   endtask

   task automatic add(input bit rst, input logic [1:0] rq, input logic nt, input int n,
                      input logic [2:0] ph, input logic dir, input logic [1:0] r,
                      input logic [1:0] y, input logic [1:0] g);
      vec_t v;
      v.rst = rst; v.req = rq; v.night = nt; v.n = n;
      v.ph = ph; v.dir = dir; v.r = r; v.y = y; v.g = g;
      tbl.push_back(v);
   endtask

   // Leaves the bench on a falling edge with reset just released.
   task automatic do_reset();
      rst_n = 1'b0; en = 1'b1; night = 1'b0; req = 2'b00; clr_fault = 1'b0;
      inj_r = 2'b00; inj_y = 2'b00; inj_g = 2'b00;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // fixed-time fallback with no demand
      add(1, 2'b00, 0, 2, AR, 1, 2'b11, 2'b00, 2'b00);
      add(0, 2'b00, 0, 8, GR, 0, 2'b10, 2'b00, 2'b01);
      add(0, 2'b00, 0, 3, YE, 0, 2'b10, 2'b01, 2'b00);
      add(0, 2'b00, 0, 2, AR, 0, 2'b11, 2'b00, 2'b00);
      add(0, 2'b00, 0, 8, GR, 1, 2'b01, 2'b00, 2'b10);
      add(0, 2'b00, 0, 3, YE, 1, 2'b01, 2'b10, 2'b00);
      add(0, 2'b00, 0, 2, AR, 1, 2'b11, 2'b00, 2'b00);
      add(0, 2'b00, 0, 1, GR, 0, 2'b10, 2'b00, 2'b01);
      // sole request on approach 0 is re-served
      add(1, 2'b01, 0, 2, AR, 1, 2'b11, 2'b00, 2'b00);
      add(0, 2'b01, 0, 8, GR, 0, 2'b10, 2'b00, 2'b01);
      add(0, 2'b01, 0, 3, YE, 0, 2'b10, 2'b01, 2'b00);
      add(0, 2'b01, 0, 2, AR, 0, 2'b11, 2'b00, 2'b00);
      add(0, 2'b01, 0, 8, GR, 0, 2'b10, 2'b00, 2'b01);
      add(0, 2'b01, 0, 3, YE, 0, 2'b10, 2'b01, 2'b00);
      add(0, 2'b01, 0, 2, AR, 0, 2'b11, 2'b00, 2'b00);
      add(0, 2'b01, 0, 1, GR, 0, 2'b10, 2'b00, 2'b01);
      // both requesting: alternate 0,1,0
      add(1, 2'b11, 0, 2, AR, 1, 2'b11, 2'b00, 2'b00);
      add(0, 2'b11, 0, 8, GR, 0, 2'b10, 2'b00, 2'b01);
      add(0, 2'b11, 0, 3, YE, 0, 2'b10, 2'b01, 2'b00);
      add(0, 2'b11, 0, 2, AR, 0, 2'b11, 2'b00, 2'b00);
      add(0, 2'b11, 0, 8, GR, 1, 2'b01, 2'b00, 2'b10);
      add(0, 2'b11, 0, 3, YE, 1, 2'b01, 2'b10, 2'b00);
      add(0, 2'b11, 0, 2, AR, 1, 2'b11, 2'b00, 2'b00);
      add(0, 2'b11, 0, 1, GR, 0, 2'b10, 2'b00, 2'b01);
      // night raised mid-green, dropped during an off half-period
      add(1, 2'b00, 0, 2, AR, 1, 2'b11, 2'b00, 2'b00);
      add(0, 2'b00, 0, 3, GR, 0, 2'b10, 2'b00, 2'b01);
      add(0, 2'b00, 1, 5, GR, 0, 2'b10, 2'b00, 2'b01);
      add(0, 2'b00, 1, 3, YE, 0, 2'b10, 2'b01, 2'b00);
      add(0, 2'b00, 1, 2, AR, 0, 2'b11, 2'b00, 2'b00);
      add(0, 2'b00, 1, 4, FL, 0, 2'b00, 2'b11, 2'b00);
      add(0, 2'b00, 1, 4, FL, 0, 2'b00, 2'b00, 2'b00);
      add(0, 2'b00, 1, 4, FL, 0, 2'b00, 2'b11, 2'b00);
      add(0, 2'b00, 1, 1, FL, 0, 2'b00, 2'b00, 2'b00);
      add(0, 2'b00, 0, 3, FL, 0, 2'b00, 2'b00, 2'b00);
      add(0, 2'b00, 0, 2, AR, 0, 2'b11, 2'b00, 2'b00);
      add(0, 2'b00, 0, 1, GR, 1, 2'b01, 2'b00, 2'b10);

      for (int i = 0; i < tbl.size(); i++) begin
         if (tbl[i].rst) do_reset();
         req   = tbl[i].req;
         night = tbl[i].night;
         for (int c = 0; c < tbl[i].n; c++) begin
            chk($sformatf("row%0d.c%0d", i, c),
                mk(tbl[i].ph, tbl[i].dir, tbl[i].r, tbl[i].y, tbl[i].g, 1'b0));
            @(negedge clk);
         end
      end

      // two greens lit: fault next cycle, all-red the one after, set beats clear
      do_reset();
      repeat (2) @(negedge clk);
      chk("flt_pre", mk(GR, 0, 2'b10, 2'b00, 2'b01, 0));
      inj_g = 2'b10;
      @(negedge clk);
      chk("flt_flag", mk(GR, 0, 2'b10, 2'b00, 2'b01, 1));
      @(negedge clk);
      chk("flt_lamps", mk(FA, 0, 2'b11, 2'b00, 2'b00, 1));
      clr_fault = 1'b1;
      @(negedge clk);
      clr_fault = 1'b0;
      chk("flt_set_wins", mk(FA, 0, 2'b11, 2'b00, 2'b00, 1));
      inj_g = 2'b00;
      @(negedge clk);
      chk("flt_hold", mk(FA, 0, 2'b11, 2'b00, 2'b00, 1));
      clr_fault = 1'b1;
      @(negedge clk);
      clr_fault = 1'b0;
      chk("flt_clr", mk(AR, 0, 2'b11, 2'b00, 2'b00, 0));
      @(negedge clk);
      chk("flt_clr_ar2", mk(AR, 0, 2'b11, 2'b00, 2'b00, 0));
      @(negedge clk);
      chk("flt_resume", mk(GR, 1, 2'b01, 2'b00, 2'b10, 0));

      // stuck yellow feedback: short glitches tolerated, three in a row are not
      do_reset();
      repeat (2) @(negedge clk);
      inj_y = 2'b10;
      repeat (2) @(negedge clk);
      inj_y = 2'b00;
      chk("mm_2cyc", mk(GR, 0, 2'b10, 2'b00, 2'b01, 0));
      @(negedge clk);
      chk("mm_match", mk(GR, 0, 2'b10, 2'b00, 2'b01, 0));
      inj_y = 2'b10;
      repeat (2) @(negedge clk);
      inj_y = 2'b00;
      chk("mm_glitch", mk(GR, 0, 2'b10, 2'b00, 2'b01, 0));
      @(negedge clk);
      chk("mm_glitch_match", mk(GR, 0, 2'b10, 2'b00, 2'b01, 0));
      inj_y = 2'b10;
      @(negedge clk);
      chk("mm_1of3", mk(GR, 0, 2'b10, 2'b00, 2'b01, 0));
      repeat (2) @(negedge clk);
      inj_y = 2'b00;
      chk("mm_3cyc", mk(YE, 0, 2'b10, 2'b01, 2'b00, 1));
      @(negedge clk);
      chk("mm_fail", mk(FA, 0, 2'b11, 2'b00, 2'b00, 1));

      // en low for 5 cycles stretches green by 5, then reset mid-yellow
      do_reset();
      repeat (4) @(negedge clk);
      en = 1'b0;
      repeat (5) @(negedge clk);
      en = 1'b1;
      chk("en_frozen", mk(GR, 0, 2'b10, 2'b00, 2'b01, 0));
      repeat (5) @(negedge clk);
      chk("en_green_last", mk(GR, 0, 2'b10, 2'b00, 2'b01, 0));
      @(negedge clk);
      chk("en_yellow", mk(YE, 0, 2'b10, 2'b01, 2'b00, 0));
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk("rst_async", mk(AR, 1, 2'b11, 2'b00, 2'b00, 0));
      @(negedge clk);
      rst_n = 1'b1;
      chk("rst_ar1", mk(AR, 1, 2'b11, 2'b00, 2'b00, 0));
      @(negedge clk);
      chk("rst_ar2", mk(AR, 1, 2'b11, 2'b00, 2'b00, 0));
      @(negedge clk);
      chk("rst_green", mk(GR, 0, 2'b10, 2'b00, 2'b01, 0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
